if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage with a DEPTH-entry prefetch FIFO between the IM port and ID.
//  Handles variable IM latency with a req/ready + rvalid handshake and at most one outstanding request.
//  Applies EXE redirects immediately: flushes the queue and discards stale in-flight responses.
//  Sits between the PC/IM memory interface and the IF/ID boundary of the 5-stage CPU.
// PARAMETERS
//  XLEN      32          address/instruction width
//  DEPTH     4           prefetch FIFO entries; power of two, >=2
//  RESET_PC  32'h0       first fetch address after reset
// PORTS
//  clk                 in   1     clock, rising edge
//  rst_n               in   1     asynchronous active-low reset
//  exe_redirect        in   1     single-cycle redirect pulse from EXE (jump/taken branch)
//  exe_redirect_addr   in   XLEN  redirect target
//  id_stall            in   1     ID hazard stall; hold head entry
//  mem_stall           in   1     MEM/AXI stall; hold head entry
//  im_req              out  1     fetch request
//  im_addr             out  XLEN  fetch address, word aligned
//  im_ready            in   1     request accepted when im_req&&im_ready
//  im_rvalid           in   1     response valid, one per accepted request
//  im_rdata            in   XLEN  instruction
//  if_valid            out  1     head entry valid toward ID
//  if_pc               out  XLEN  head entry PC
//  if_inst             out  XLEN  head entry instruction
//  perf_fetch_cnt      out  32    [IF_PERF_CNT_EN only] responses pushed
//  perf_flush_cnt      out  32    [IF_PERF_CNT_EN only] redirects applied
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_PC, FIFO empty, FSM=IDLE; im_req=0, if_valid=0, if_pc=0, if_inst=0, counters=0.
//  FSM IDLE: im_req=1 when (count + 0) < DEPTH; handshake -> WAIT, pc_q<=pc_q+4 (mod 2^XLEN).
//  FSM WAIT: im_req=0; on im_rvalid push {req_pc, im_rdata} -> IDLE.
//  FSM DROP: im_req=0; on im_rvalid discard data -> IDLE.
//  Once im_req=1, im_req and im_addr hold stable until im_ready, even across a redirect.
//  Space rule: issue only if count < DEPTH; the push then always has room. With DEPTH free slots, steady 1 instr / 2 cycles for zero-latency IM.
//  Redirect (exe_redirect=1), applied regardless of id_stall/mem_stall:
//   - FIFO flushed (count=0) at next edge; pc_q <= {exe_redirect_addr[XLEN-1:2],2'b00}.
//   - If a request is accepted that cycle or is outstanding (WAIT) -> DROP; rvalid in the same cycle is discarded.
//   - If im_req is pending and not yet accepted, it is marked stale; on its acceptance -> DROP.
//   - Stale acceptance does not advance pc_q.
//  Output: if_valid = !empty && !exe_redirect; if_pc/if_inst = head entry (0 when empty).
//  Pop when if_valid && !id_stall && !mem_stall. Push and pop in the same cycle: count is unchanged.
//  Push into empty FIFO: if_valid rises the cycle after rvalid. No bypass.
//  Pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH)+1 bits.
//  First im_req is asserted in the first cycle after rst_n deasserts.
//  Reset mid-operation: an outstanding response arriving after reset release, with no request accepted since reset, is ignored.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//   - perf ports exist.
//   - perf_fetch_cnt +1 per pushed response; perf_flush_cnt +1 per exe_redirect cycle.
//   - Both counters wrap at 2^32.
//  IF_PERF_CNT_EN undefined: perf ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset release, im_ready=1, rvalid 1 cycle after accept, no stalls -> im_addr 0,4,8...; if_pc 0,4,8 in order, if_inst matches memory.
//  2. id_stall=1 for 10 cycles, DEPTH=4 -> 4 entries buffered, im_req=0 while full; release -> pops 4 in order, no loss or duplication.
//  3. Redirect to 0x101 while a request at 0x8 is in WAIT -> 0x8 response dropped, next im_addr=0x100, queue empty, if_valid=0 in redirect cycle.
//  4. Redirect with im_req pending and im_ready=0 for 3 cycles -> im_addr holds old value, its response is dropped, then fetch 0x100.
//  5. Redirect coincident with im_rvalid and a pop under mem_stall=0 -> rvalid data discarded, nothing popped, next if_pc=target.
//  6. rst_n asserted mid-WAIT -> outputs 0 immediately; after release fetch restarts at RESET_PC; with IF_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: a single-outstanding IM requester feeding a DEPTH-entry prefetch FIFO toward ID.
// Optional macro IF_PERF_CNT_EN adds the perf_fetch_cnt / perf_flush_cnt counters.
module if_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exe_redirect,
  input  logic [XLEN-1:0] exe_redirect_addr,
  input  logic            id_stall,
  input  logic            mem_stall,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_ready,
  input  logic            im_rvalid,
  input  logic [XLEN-1:0] im_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic [1:0]      dbg_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int              AW          = $clog2(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  // Request handshake: a request transfers in the cycle im_req && im_ready; once raised, im_req and
  // im_addr hold until that cycle. Exactly one im_rvalid follows each transferred request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            pend_q;
  logic [XLEN-1:0] pend_addr_q;
  logic            stale_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic has_space;
  logic not_empty;
  logic accept;
  logic push;
  logic pop;

  assign has_space = count < (AW+1)'(DEPTH);
  assign not_empty = count != '0;
  assign im_req    = rst_n && (state_q == S_IDLE) && (pend_q || has_space);
  assign im_addr   = pend_q ? pend_addr_q : pc_q;
  assign accept    = im_req && im_ready;
  assign push      = (state_q == S_WAIT) && im_rvalid && !exe_redirect;
  assign if_valid  = not_empty && !exe_redirect;
  assign pop       = if_valid && !id_stall && !mem_stall;
  assign if_pc     = not_empty ? pc_mem[rd_ptr]   : '0;
  assign if_inst   = not_empty ? inst_mem[rd_ptr] : '0;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (stale_q || exe_redirect) ? S_DROP : S_WAIT;
      // A response landing in the redirect cycle is already discarded, so no DROP is needed.
      S_WAIT: begin
        if (exe_redirect)   state_d = im_rvalid ? S_IDLE : S_DROP;
        else if (im_rvalid) state_d = S_IDLE;
      end
      S_DROP: if (im_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC_AL;
      req_pc_q    <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (exe_redirect)          pc_q <= exe_redirect_addr & ALIGN_MASK;
      else if (accept && !stale_q) pc_q <= pc_q + XLEN'(4);
      if (accept) req_pc_q <= im_addr;
      pend_q <= im_req && !im_ready;
      if (im_req && !im_ready) pend_addr_q <= im_addr;
      // A redirect under a held request poisons it; its eventual transfer goes to DROP.
      if (accept)                      stale_q <= 1'b0;
      else if (exe_redirect && im_req) stale_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (exe_redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc_q;
      inst_mem[wr_ptr] <= im_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push)         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (exe_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios plus a randomized run against a queue-based fetch model.
module tb_if_prefetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exe_redirect = 1'b0;
  logic [31:0] exe_redirect_addr = '0;
  logic        id_stall = 1'b0;
  logic        mem_stall = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .exe_redirect(exe_redirect), .exe_redirect_addr(exe_redirect_addr),
    .id_stall(id_stall), .mem_stall(mem_stall),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .dbg_state(dbg_state)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];          // PCs expected in the prefetch queue, head first
  logic [31:0] fetch_exp;         // next sequential address a live fetch must use
  int          gen = 0;           // bumps on every redirect or reset
  int          cur_req_gen = 0;
  int          rsp_gen = 0;
  bit          prev_pend = 0;
  logic [31:0] prev_addr = '0;
  bit          rsp_valid = 0;
  bit          rsp_orphan = 0;
  int          rsp_wait = 0;
  logic [31:0] rsp_addr = '0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  int          pushes = 0;
  int          flushes = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: check DUT outputs against the model, advance model and IM responder.
  task automatic tick();
    bit          exp_valid, exp_req, acc, pop_m, push_m, redir;
    logic [31:0] eh, a_s, tgt;
    #1;
    exp_valid = (exp_q.size() != 0) && !exe_redirect;
    eh        = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    exp_req   = (rsp_valid && !rsp_orphan) ? 1'b0 : (exp_q.size() < DEPTH);
    checks++;
    if (if_valid !== exp_valid) begin
      errors++; $display("FAIL if_valid: got %0b expected %0b t=%0t", if_valid, exp_valid, $time);
    end
    checks++;
    if (if_pc !== eh || if_inst !== ((exp_q.size() != 0) ? mem_f(eh) : 32'h0)) begin
      errors++; $display("FAIL head: got pc %h inst %h expected pc %h t=%0t", if_pc, if_inst, eh, $time);
    end
    checks++;
    if (im_req !== exp_req) begin
      errors++; $display("FAIL im_req: got %0b expected %0b t=%0t", im_req, exp_req, $time);
    end
    if (prev_pend) begin
      checks++;
      if (im_req !== 1'b1 || im_addr !== prev_addr) begin
        errors++; $display("FAIL req_hold: got req %0b addr %h expected 1 %h", im_req, im_addr, prev_addr);
      end
    end
    if (im_req && im_addr[1:0] != 2'b00) begin
      errors++; $display("FAIL align: got addr %h expected word aligned", im_addr);
    end
    if (im_req && !prev_pend) cur_req_gen = gen;
    acc    = im_req && im_ready;
    a_s    = im_addr;
    pop_m  = exp_valid && !id_stall && !mem_stall;
    redir  = exe_redirect;
    tgt    = exe_redirect_addr & 32'hFFFF_FFFC;
    push_m = im_rvalid && rsp_valid && !rsp_orphan && !redir && (rsp_gen == gen);
    if (push_m) begin
      checks++;
      if (rsp_addr !== fetch_exp) begin
        errors++; $display("FAIL fetch_addr: got %h expected %h", rsp_addr, fetch_exp);
      end
    end
    prev_pend = im_req && !im_ready;
    prev_addr = im_addr;
    @(posedge clk);
    if (pop_m) void'(exp_q.pop_front());
    if (push_m) begin exp_q.push_back(rsp_addr); fetch_exp += 32'd4; pushes++; end
    if (redir) begin exp_q.delete(); fetch_exp = tgt; gen++; flushes++; end
    if (im_rvalid) begin rsp_valid = 0; rsp_orphan = 0; end
    else if (rsp_valid && rsp_wait > 0) rsp_wait--;
    if (acc) begin
      rsp_valid = 1; rsp_addr = a_s; rsp_gen = cur_req_gen;
      rsp_wait = $urandom_range(lat_hi, lat_lo);
    end
    @(negedge clk);
    im_rvalid = rsp_valid && (rsp_wait == 0);
    im_rdata  = im_rvalid ? mem_f(rsp_addr) : $urandom;
  endtask

  task automatic model_reset();
    exp_q.delete();
    fetch_exp = RESET_PC;
    gen++;
    prev_pend = 0;
    pushes = 0;
    flushes = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; exe_redirect = 0; id_stall = 0; mem_stall = 0; im_ready = 0;
    im_rvalid = 0; rsp_valid = 0; rsp_orphan = 0; lat_lo = 0; lat_hi = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++;
    if (im_req !== 0 || if_valid !== 0 || if_pc !== 0 || if_inst !== 0) begin
      errors++; $display("FAIL reset_outputs: got req %0b valid %0b pc %h inst %h expected all 0",
                         im_req, if_valid, if_pc, if_inst);
    end
    do_reset();
    #1;
    checks++;
    if (im_req !== 1 || im_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req: got req %0b addr %h expected 1 %h", im_req, im_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int npop = 0, nacc = 0;
    do_reset();
    im_ready = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (im_req) begin
        checks++;
        if (im_addr !== 32'(nacc * 4)) begin
          errors++; $display("FAIL stream_addr: got %h expected %h", im_addr, 32'(nacc * 4));
        end
        nacc++;
      end
      if (if_valid) begin
        checks++;
        if (if_pc !== 32'(npop * 4) || if_inst !== mem_f(32'(npop * 4))) begin
          errors++; $display("FAIL stream_pop: got %h expected %h", if_pc, 32'(npop * 4));
        end
        npop++;
      end
      tick();
    end
    checks++;
    if (npop != 9) begin
      errors++; $display("FAIL stream_rate: got %0d pops expected 9", npop);
    end
  endtask

  task automatic test_id_stall();
    do_reset();
    im_ready = 1; id_stall = 1;
    repeat (10) tick();
    #1;
    checks++;
    if (im_req !== 0 || if_valid !== 1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL full_hold: got req %0b valid %0b pc %h expected 0 1 0", im_req, if_valid, if_pc);
    end
    id_stall = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++;
      if (if_valid !== 1 || if_pc !== 32'(i * 4)) begin
        errors++; $display("FAIL drain: got valid %0b pc %h expected 1 %h", if_valid, if_pc, 32'(i * 4));
      end
      tick();
    end
  endtask

  task automatic test_redirect_wait();
    int i;
    do_reset();
    im_ready = 1; id_stall = 1;
    for (i = 0; i < 20; i++) begin #1; if (im_req && im_addr == 32'h8) break; tick(); end
    lat_lo = 3; lat_hi = 3;
    tick();
    exe_redirect = 1; exe_redirect_addr = 32'h101;
    #1;
    checks++;
    if (if_valid !== 0) begin
      errors++; $display("FAIL redir_valid: got %0b expected 0", if_valid);
    end
    tick();
    exe_redirect = 0; id_stall = 0; lat_lo = 0; lat_hi = 0;
    #1;
    checks++;
    if (if_valid !== 0 || im_req !== 0) begin
      errors++; $display("FAIL redir_flush: got valid %0b req %0b expected 0 0", if_valid, im_req);
    end
    for (i = 0; i < 10; i++) begin #1; if (im_req) break; tick(); end
    checks++;
    if (im_req !== 1 || im_addr !== 32'h100) begin
      errors++; $display("FAIL redir_next: got req %0b addr %h expected 1 100", im_req, im_addr);
    end
    for (i = 0; i < 10; i++) begin #1; if (if_valid) break; tick(); end
    checks++;
    if (if_valid !== 1 || if_pc !== 32'h100) begin
      errors++; $display("FAIL redir_head: got valid %0b pc %h expected 1 100", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_pending();
    int i;
    do_reset();
    im_ready = 1;
    for (i = 0; i < 20; i++) begin #1; if (im_req && im_addr == 32'h8) break; tick(); end
    im_ready = 0;
    tick();
    exe_redirect = 1; exe_redirect_addr = 32'h101;
    for (i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (im_req !== 1 || im_addr !== 32'h8) begin
        errors++; $display("FAIL pend_hold: got req %0b addr %h expected 1 8", im_req, im_addr);
      end
      tick();
      exe_redirect = 0;
    end
    im_ready = 1;
    tick();
    for (i = 0; i < 10; i++) begin #1; if (im_req) break; tick(); end
    checks++;
    if (im_req !== 1 || im_addr !== 32'h100) begin
      errors++; $display("FAIL pend_next: got req %0b addr %h expected 1 100", im_req, im_addr);
    end
    for (i = 0; i < 10; i++) begin #1; if (if_valid) break; tick(); end
    checks++;
    if (if_valid !== 1 || if_pc !== 32'h100) begin
      errors++; $display("FAIL pend_head: got valid %0b pc %h expected 1 100", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_rvalid();
    int i;
    do_reset();
    im_ready = 1; id_stall = 1;
    for (i = 0; i < 20; i++) begin #1; if (if_valid && im_rvalid) break; tick(); end
    id_stall = 0; mem_stall = 0;
    exe_redirect = 1; exe_redirect_addr = 32'h300;
    #1;
    checks++;
    if (if_valid !== 0 || im_rvalid !== 1) begin
      errors++; $display("FAIL coinc_setup: got valid %0b rvalid %0b expected 0 1", if_valid, im_rvalid);
    end
    tick();
    exe_redirect = 0;
    #1;
    checks++;
    if (if_valid !== 0) begin
      errors++; $display("FAIL coinc_flush: got %0b expected 0", if_valid);
    end
    for (i = 0; i < 10; i++) begin #1; if (if_valid) break; tick(); end
    checks++;
    if (if_valid !== 1 || if_pc !== 32'h300 || if_inst !== mem_f(32'h300)) begin
      errors++; $display("FAIL coinc_head: got valid %0b pc %h expected 1 300", if_valid, if_pc);
    end
  endtask

  task automatic test_reset_mid_wait();
    int i;
    do_reset();
    im_ready = 1; id_stall = 1;
    repeat (4) tick();
    lat_lo = 5; lat_hi = 5;
    for (i = 0; i < 10; i++) begin #1; if (im_req) break; tick(); end
    tick();
    rst_n = 0;
    #1;
    checks++;
    if (im_req !== 0 || if_valid !== 0 || if_pc !== 0 || if_inst !== 0) begin
      errors++; $display("FAIL midrst_out: got req %0b valid %0b pc %h inst %h expected all 0",
                         im_req, if_valid, if_pc, if_inst);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 0 || perf_flush_cnt !== 0) begin
      errors++; $display("FAIL midrst_perf: got %0d %0d expected 0 0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
    model_reset();
    id_stall = 0; lat_lo = 0; lat_hi = 0;
    rsp_orphan = 1; rsp_wait = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; im_ready = 0;
    im_rvalid = 1; im_rdata = mem_f(rsp_addr);
    tick();
    im_ready = 1;
    #1;
    checks++;
    if (im_req !== 1 || im_addr !== RESET_PC) begin
      errors++; $display("FAIL midrst_req: got req %0b addr %h expected 1 %h", im_req, im_addr, RESET_PC);
    end
    repeat (10) tick();
  endtask

  task automatic test_random();
    do_reset();
    lat_lo = 0; lat_hi = 3;
    for (int c = 0; c < 1500; c++) begin
      im_ready     = ($urandom_range(3, 0) != 0);
      id_stall     = ($urandom_range(3, 0) == 0);
      mem_stall    = ($urandom_range(7, 0) == 0);
      exe_redirect = ($urandom_range(15, 0) == 0);
      exe_redirect_addr = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF5 : $urandom;
      tick();
    end
    exe_redirect = 0;
`ifdef IF_PERF_CNT_EN
    #1;
    checks++;
    if (perf_fetch_cnt !== 32'(pushes) || perf_flush_cnt !== 32'(flushes)) begin
      errors++; $display("FAIL perf: got %0d %0d expected %0d %0d",
                         perf_fetch_cnt, perf_flush_cnt, pushes, flushes);
    end
`endif
  endtask

  initial begin
    fetch_exp = RESET_PC;
    test_reset();
    test_stream();
    test_id_stall();
    test_redirect_wait();
    test_redirect_pending();
    test_redirect_rvalid();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
